// File: rtl/mux_bist_ctrl.sv
// Exhaustive BIST controller for a 4:1 single-bit mux.
// Define MUX_BIST_MISR_EN to add an 8-bit MISR signature output.
module mux_bist_ctrl #(
   parameter int SETTLE_CYCLES = 1,
   parameter int FAIL_CNT_W    = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  mux_out,
   output logic                  mux_a,
   output logic                  mux_b,
   output logic                  mux_c,
   output logic                  mux_d,
   output logic [1:0]            mux_sel,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  fault_indicator,
   output logic [FAIL_CNT_W-1:0] fail_count,
   output logic [5:0]            first_fail_idx
`ifdef MUX_BIST_MISR_EN
   ,
   output logic [7:0]            signature
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_APPLY,
      S_CAPTURE,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t                r_state;
   state_t                w_next;
   logic [5:0]            r_idx;
   logic [3:0]            r_settle;
   logic [FAIL_CNT_W-1:0] r_fail_cnt;
   logic [5:0]            r_first;
   logic                  r_fault;

   logic       w_launch;
   logic       w_settled;
   logic       w_capture;
   logic [3:0] w_pat;
   logic       w_expected;
   logic       w_mismatch;
   logic       w_drive;

   assign w_launch   = start &&
                       (r_state == S_IDLE || r_state == S_DONE);
   assign w_settled  = (r_settle == SETTLE_LAST);
   assign w_capture  = (r_state == S_CAPTURE);
   assign w_pat      = r_idx[3:0];
   assign w_expected = w_pat[r_idx[5:4]];
   assign w_mismatch = w_capture && (mux_out != w_expected);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (w_launch) w_next = S_APPLY;
         end
         S_APPLY: begin
            if (w_settled) w_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_next = (r_idx == 6'd63) ? S_DONE : S_APPLY;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx      <= '0;
         r_settle   <= '0;
         r_fail_cnt <= '0;
         r_first    <= '0;
         r_fault    <= 1'b0;
      end else if (w_launch) begin
         r_idx      <= '0;
         r_settle   <= '0;
         r_fail_cnt <= '0;
         r_first    <= '0;
         r_fault    <= 1'b0;
      end else begin
         if (r_state == S_APPLY) begin
            r_settle <= w_settled ? 4'd0 : r_settle + 4'd1;
         end
         if (w_capture && r_idx != 6'd63) begin
            r_idx <= r_idx + 6'd1;
         end
         // fail count saturates; first index latches only once per run
         if (w_mismatch) begin
            if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
            if (!r_fault) begin
               r_first <= r_idx;
               r_fault <= 1'b1;
            end
         end
      end
   end

`ifdef MUX_BIST_MISR_EN
   logic [7:0] r_sig;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sig <= '0;
      end else if (w_launch) begin
         r_sig <= '0;
      end else if (w_capture) begin
         r_sig <= {r_sig[6:0], 1'b0}
                ^ ({8{r_sig[7]}} & 8'h1D)
                ^ {7'b0, mux_out};
      end
   end

   assign signature = r_sig;
`endif

   assign w_drive = (r_state != S_IDLE);

   assign mux_a   = w_drive & r_idx[0];
   assign mux_b   = w_drive & r_idx[1];
   assign mux_c   = w_drive & r_idx[2];
   assign mux_d   = w_drive & r_idx[3];
   assign mux_sel = {2{w_drive}} & r_idx[5:4];

   assign busy            = (r_state == S_APPLY) ||
                            (r_state == S_CAPTURE);
   assign done            = (r_state == S_DONE);
   assign pass            = done && (r_fail_cnt == '0);
   assign fault_indicator = r_fault;
   assign fail_count      = r_fail_cnt;
   assign first_fail_idx  = r_first;

endmodule

// File: tb/tb_mux_bist_ctrl.sv
// Bench for mux_bist_ctrl: a faultable mux model plus a per-run
// reference computed over all 64 patterns.
module tb_mux_bist_ctrl;

   localparam int S    = 1;
   localparam int FW   = 7;
   localparam int LAT  = 64 * (S + 1);
   localparam int LIM  = LAT + 50;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          mux_out;
   logic          mux_a;
   logic          mux_b;
   logic          mux_c;
   logic          mux_d;
   logic [1:0]    mux_sel;
   logic          busy;
   logic          done;
   logic          pass;
   logic          fault_indicator;
   logic [FW-1:0] fail_count;
   logic [5:0]    first_fail_idx;
`ifdef MUX_BIST_MISR_EN
   logic [7:0]    signature;
`endif

   int n_tests;
   int n_fail;
   int fault;

   mux_bist_ctrl #(
      .SETTLE_CYCLES(S),
      .FAIL_CNT_W(FW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .mux_out(mux_out),
      .mux_a(mux_a),
      .mux_b(mux_b),
      .mux_c(mux_c),
      .mux_d(mux_d),
      .mux_sel(mux_sel),
      .busy(busy),
      .done(done),
      .pass(pass),
      .fault_indicator(fault_indicator),
      .fail_count(fail_count),
`ifdef MUX_BIST_MISR_EN
      .signature(signature),
`endif
      .first_fail_idx(first_fail_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 0 good, 1 out stuck-0, 2 out stuck-1, 3 sel[0] stuck-0
   function automatic bit mux_model(input int mode, input int i);
      int sel;
      sel = i / 16;
      if (mode == 3) sel = sel & 2;
      case (mode)
         1:       return 1'b0;
         2:       return 1'b1;
         default: return bit'((i >> sel) & 1);
      endcase
   endfunction

   assign mux_out = mux_model(fault,
      int'({mux_sel, mux_d, mux_c, mux_b, mux_a}));

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk(tag, {mux_a, mux_b, mux_c, mux_d, mux_sel, busy, done,
                pass, fault_indicator, fail_count, first_fail_idx}, 0);
`ifdef MUX_BIST_MISR_EN
      chk({tag, "_sig"}, signature, 0);
`endif
   endtask

   task automatic run_test(input int mode, input bit inject);
      int exp_cnt;
      int exp_first;
      int n;
      int busy_bad;
      int hold;
      bit seen;
      bit b;
      logic [7:0] s;
      exp_cnt   = 0;
      exp_first = 0;
      seen      = 0;
      s         = 0;
      for (int i = 0; i < 64; i++) begin
         b = mux_model(mode, i);
         if (b != mux_model(0, i)) begin
            exp_cnt++;
            if (!seen) exp_first = i;
            seen = 1;
         end
         s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, b};
      end
      if (exp_cnt > (1 << FW) - 1) exp_cnt = (1 << FW) - 1;
      fault = mode;

      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk("launch", {busy, done, fault_indicator, fail_count},
          {1'b1, 1'b0, 1'b0, {FW{1'b0}}});
`ifdef MUX_BIST_MISR_EN
      chk("sig_clear", signature, 0);
`endif
      chk("pat0", {mux_sel, mux_d, mux_c, mux_b, mux_a}, 0);

      n        = 0;
      busy_bad = 0;
      while (!done && n < LIM) begin
         @(posedge clk);
         n++;
         #1;
         start = inject && n < LAT - 8 && $urandom_range(0, 7) == 0;
         if (!done && !busy) busy_bad++;
      end
      start = 1'b0;
      chk("done_lat", n, LAT);
      chk("busy_hold", busy_bad, 0);
      chk("busy_low", busy, 0);
      chk("fail_cnt", fail_count, exp_cnt);
      chk("first_idx", first_fail_idx, exp_first);
      chk("fault_ind", fault_indicator, exp_cnt != 0);
      chk("pass", pass, exp_cnt == 0);
      chk("pat63", {mux_sel, mux_d, mux_c, mux_b, mux_a}, 6'h3F);
`ifdef MUX_BIST_MISR_EN
      chk("sig", signature, s);
`endif
      hold = $urandom_range(1, 5);
      repeat (hold) @(posedge clk);
      #1;
      chk("hold", {done, pass, fail_count, first_fail_idx},
          {1'b1, exp_cnt == 0, FW'(exp_cnt), 6'(exp_first)});
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      fault   = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      #12;
      chk_reset_vals("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk_reset_vals("idle");

      run_test(0, 1'b0);
      run_test(1, 1'b1);
      run_test(2, 1'b0);
      run_test(3, 1'b1);

      // reset mid-run at idx 20 of a stuck-at-0 run
      fault = 1;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2 * 20) @(posedge clk);
      #1;
      chk("pre_rst", {busy, fault_indicator}, 2'b11);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("mid_rst");
      repeat (3) @(posedge clk);
      #1 chk_reset_vals("rst_hold");
      rst_n = 1'b1;
      run_test(1, 1'b0);

      for (int k = 0; k < 6; k++) begin
         run_test($urandom_range(0, 3), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
